ising_frame_streamer: RTL and testbench

- Downstream consumer of ising_model_top: on each update_tick, snapshots spin_states, system_energy and system_magnetization.
- Serializes the snapshot into a checksummed byte frame on a ready/valid byte stream, which feeds the host UART/debug link.
- Ticks that arrive while a frame is still in flight are dropped and counted, never queued.

---
 rtl/ising_pkg.sv | 17 +
 rtl/ising_frame_streamer.sv | 236 +++++++++++++++++++++++
 tb/tb_ising_frame_streamer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ising_pkg.sv
// Shared definitions for the Ising lattice frame streamer: frame header,
// streamer FSM states and the spin payload size helper.
package ising_pkg;

    localparam logic [7:0] HEADER_BYTE = 8'hA5;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } frame_state_t;

    // Number of whole bytes needed to carry a grid*grid spin lattice.
    function automatic int nb_bytes(input int grid);
        return (grid * grid + 32'sd7) / 32'sd8;
    endfunction

endpackage

// File: rtl/ising_frame_streamer.sv
// Snapshots the Ising lattice state on each update tick and streams it out as
// a checksummed byte frame on a ready/valid byte interface. Ticks arriving
// while a frame is in flight are dropped and counted, never queued.
module ising_frame_streamer
    import ising_pkg::*;
#(
    parameter int         GRID_SIZE = 4,
    parameter logic [7:0] HEADER    = HEADER_BYTE
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic                           update_tick,
    input  logic [GRID_SIZE*GRID_SIZE-1:0] spin_states,
    input  logic [15:0]                    system_energy,
    input  logic [15:0]                    system_magnetization,
    output logic [7:0]                     m_tdata,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic                           m_tlast,
    output logic                           busy,
    output logic [7:0]                     seq_num,
    output logic [15:0]                    drop_count,
    output logic                           overrun,
    input  logic                           clear_overrun
);

    localparam int NBITS = GRID_SIZE * GRID_SIZE;
    localparam int NB    = nb_bytes(GRID_SIZE);
    localparam int LAST  = 6 + NB;
    localparam int IDXW  = $clog2(LAST + 1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LAST);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1'b1);
    localparam logic [IDXW-1:0] IDX_ZERO = {IDXW{1'b0}};

    frame_state_t      state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              tick_prev_q, tick_prev_d;
    logic [NB*8-1:0]   spin_q, spin_d;
    logic [15:0]       energy_q, energy_d;
    logic [15:0]       mag_q, mag_d;
    logic [7:0]        seq_q, seq_d;
    logic [7:0]        chk_q, chk_d;
    logic [7:0]        tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic [15:0]       drop_q, drop_d;
    logic              overrun_q, overrun_d;

    logic              tick_ev_s, hs_s, last_hs_s, start_s, drop_s, load_s;
    logic [IDXW-1:0]   idx_inc_s;
    logic [7:0]        sum_acc_s;
    logic [NB*8-1:0]   spin_pad_s;

    // Byte presented at a given frame position (checksum position excluded).
    function automatic logic [7:0] frame_byte(
        input logic [IDXW-1:0] idx,
        input logic [7:0]      seq,
        input logic [15:0]     e,
        input logic [15:0]     m,
        input logic [NB*8-1:0] spins
    );
        logic [NB*8-1:0] shifted;
        logic [7:0]      b;
        int              k;
        k       = int'(idx) - 32'sd6;
        shifted = {(NB*8){1'b0}};
        case (int'(idx))
            32'sd0:  b = HEADER;
            32'sd1:  b = seq;
            32'sd2:  b = e[15:8];
            32'sd3:  b = e[7:0];
            32'sd4:  b = m[15:8];
            32'sd5:  b = m[7:0];
            default: begin
                if (k < NB) begin
                    shifted = spins >> (32'sd8 * k);
                    b       = shifted[7:0];
                end else begin
                    b = 8'h00;
                end
            end
        endcase
        return b;
    endfunction

    // Event decode: tick edge, handshakes, frame start and drop conditions.
    always_comb begin
        tick_ev_s = update_tick & ~tick_prev_q;
        hs_s      = tvalid_q & m_tready;
        last_hs_s = hs_s & (idx_q == LAST_IDX);
        start_s   = tick_ev_s & enable & ((state_q == IDLE) | last_hs_s);
        drop_s    = tick_ev_s & enable & (state_q == SEND) & ~last_hs_s;
        idx_inc_s = idx_q + IDX_ONE;
        // Header is not part of the checksum; every later byte is summed.
        if (idx_q != IDX_ZERO) begin
            sum_acc_s = chk_q + tdata_q;
        end else begin
            sum_acc_s = chk_q;
        end
        spin_pad_s              = {(NB*8){1'b0}};
        spin_pad_s[NBITS-1:0]   = spin_states;
    end

    // Next-state, byte sequencing and drop/overrun bookkeeping.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tick_prev_d = update_tick;
        spin_d      = spin_q;
        energy_d    = energy_q;
        mag_d       = mag_q;
        seq_d       = seq_q;
        chk_d       = chk_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        drop_d      = drop_q;
        overrun_d   = overrun_q;
        load_s      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_s) begin
                    load_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (hs_s) begin
                    if (idx_q == LAST_IDX) begin
                        if (start_s) begin
                            load_s = 1'b1;
                        end else begin
                            state_d  = IDLE;
                            idx_d    = IDX_ZERO;
                            tvalid_d = 1'b0;
                            tdata_d  = 8'h00;
                            tlast_d  = 1'b0;
                        end
                    end else begin
                        idx_d   = idx_inc_s;
                        chk_d   = sum_acc_s;
                        tlast_d = (idx_inc_s == LAST_IDX);
                        if (idx_inc_s == LAST_IDX) begin
                            tdata_d = 8'h00 - sum_acc_s;
                        end else begin
                            tdata_d = frame_byte(idx_inc_s, seq_q, energy_q, mag_q, spin_q);
                        end
                    end
                end else begin
                    state_d = SEND;
                end
            end
            default: begin
                state_d  = IDLE;
                tvalid_d = 1'b0;
            end
        endcase

        // Start of a new frame: snapshot inputs and present the header.
        if (load_s) begin
            state_d  = SEND;
            idx_d    = IDX_ZERO;
            spin_d   = spin_pad_s;
            energy_d = system_energy;
            mag_d    = system_magnetization;
            seq_d    = seq_q + 8'd1;
            chk_d    = 8'h00;
            tdata_d  = HEADER;
            tvalid_d = 1'b1;
            tlast_d  = 1'b0;
        end else begin
            seq_d = seq_q;
        end

        // Clear takes priority over a simultaneous drop.
        if (clear_overrun) begin
            drop_d    = 16'h0000;
            overrun_d = 1'b0;
        end else if (drop_s) begin
            overrun_d = 1'b1;
            if (drop_q != 16'hFFFF) begin
                drop_d = drop_q + 16'd1;
            end else begin
                drop_d = drop_q;
            end
        end else begin
            drop_d    = drop_q;
            overrun_d = overrun_q;
        end
    end

    // State register; asynchronous reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= IDX_ZERO;
            tick_prev_q <= 1'b0;
            spin_q      <= {(NB*8){1'b0}};
            energy_q    <= 16'h0000;
            mag_q       <= 16'h0000;
            seq_q       <= 8'h00;
            chk_q       <= 8'h00;
            tdata_q     <= 8'h00;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            drop_q      <= 16'h0000;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tick_prev_q <= tick_prev_d;
            spin_q      <= spin_d;
            energy_q    <= energy_d;
            mag_q       <= mag_d;
            seq_q       <= seq_d;
            chk_q       <= chk_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            drop_q      <= drop_d;
            overrun_q   <= overrun_d;
        end
    end

    assign m_tdata    = tdata_q;
    assign m_tvalid   = tvalid_q;
    assign m_tlast    = tlast_q;
    assign busy       = (state_q == SEND);
    assign seq_num    = seq_q;
    assign drop_count = drop_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_ising_frame_streamer.sv
// Self-checking bench for ising_frame_streamer: directed scenarios plus
// randomized frames compared against a byte-level frame model.
module tb_ising_frame_streamer;

    localparam int G     = 4;
    localparam int NBITS = G * G;
    localparam int NB    = (NBITS + 7) / 8;
    localparam int FL    = 7 + NB;

    logic             clk;
    logic             rst_n;
    logic             enable;
    logic             update_tick;
    logic [NBITS-1:0] spin_states;
    logic [15:0]      system_energy;
    logic [15:0]      system_magnetization;
    logic [7:0]       m_tdata;
    logic             m_tvalid;
    logic             m_tready;
    logic             m_tlast;
    logic             busy;
    logic [7:0]       seq_num;
    logic [15:0]      drop_count;
    logic             overrun;
    logic             clear_overrun;

    ising_frame_streamer #(.GRID_SIZE(G)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .enable               (enable),
        .update_tick          (update_tick),
        .spin_states          (spin_states),
        .system_energy        (system_energy),
        .system_magnetization (system_magnetization),
        .m_tdata              (m_tdata),
        .m_tvalid             (m_tvalid),
        .m_tready             (m_tready),
        .m_tlast              (m_tlast),
        .busy                 (busy),
        .seq_num              (seq_num),
        .drop_count           (drop_count),
        .overrun              (overrun),
        .clear_overrun        (clear_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Byte capture and stall-stability tracking, sampled on the falling edge.
    logic [8:0] cap [0:1023];
    int         wr_ptr = 0;
    int         stab_err = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;

    always @(negedge clk) begin
        if (rst_n && m_tvalid && m_tready && wr_ptr < 1024) begin
            cap[wr_ptr] <= {m_tlast, m_tdata};
            wr_ptr      <= wr_ptr + 1;
        end
        if (rst_n && prev_valid && !prev_ready &&
            !(m_tvalid === 1'b1 && m_tdata === prev_data && m_tlast === prev_last)) begin
            stab_err <= stab_err + 1;
        end
        prev_valid <= rst_n && m_tvalid;
        prev_ready <= m_tready;
        prev_data  <= m_tdata;
        prev_last  <= m_tlast;
    end

    int rd_ptr     = 0;
    int ready_mode = 0;

    task automatic step();
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: header, seq, energy, magnetization, spin bytes, then
    // the byte that makes everything after the header sum to 0 mod 256.
    task automatic model_frame(input logic [7:0] seq, input logic [15:0] e,
                               input logic [15:0] m, input logic [NBITS-1:0] sp,
                               output logic [7:0] f [FL]);
        int sum;
        f[0] = 8'hA5;
        f[1] = seq;
        f[2] = e[15:8];
        f[3] = e[7:0];
        f[4] = m[15:8];
        f[5] = m[7:0];
        for (int k = 0; k < NB; k++) begin
            f[6+k] = 8'h00;
            for (int b = 0; b < 8; b++) begin
                if (8 * k + b < NBITS) f[6+k][b] = sp[8*k+b];
            end
        end
        sum = 0;
        for (int i = 1; i < FL - 1; i++) sum += int'(f[i]);
        f[FL-1] = 8'((256 - (sum % 256)) % 256);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] seq, input logic [15:0] e,
                               input logic [15:0] m, input logic [NBITS-1:0] sp);
        logic [7:0]  f [FL];
        logic [31:0] obs;
        model_frame(seq, e, m, sp, f);
        for (int k = 0; k < FL; k++) begin
            if (rd_ptr < wr_ptr) begin
                obs = {23'd0, cap[rd_ptr]};
                rd_ptr++;
            end else begin
                obs = 32'hDEAD_0000;
            end
            chk($sformatf("%s byte%0d {last,data}", tag, k), obs,
                {23'd0, (k == FL - 1), f[k]});
        end
    endtask

    task automatic tick();
        update_tick = 1'b1;
        step();
        update_tick = 1'b0;
    endtask

    task automatic set_snap(input logic [15:0] e, input logic [15:0] m, input logic [NBITS-1:0] sp);
        system_energy        = e;
        system_magnetization = m;
        spin_states          = sp;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int n = 0; n < budget && busy; n++) step();
        chk({tag, " idle within budget"}, {31'd0, busy}, 32'd0);
    endtask

    logic [15:0]      ea, ma, eb, mb;
    logic [NBITS-1:0] sa, sb;
    logic [7:0]       exp_seq;
    int               guard;

    initial begin
        rst_n = 1'b0; enable = 1'b1; update_tick = 1'b0; clear_overrun = 1'b0;
        m_tready = 1'b1;
        set_snap(16'h0000, 16'h0000, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset m_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("reset m_tlast", {31'd0, m_tlast}, 32'd0);
        chk("reset m_tdata", {24'd0, m_tdata}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset seq_num", {24'd0, seq_num}, 32'd0);
        chk("reset drop_count", {16'd0, drop_count}, 32'd0);
        chk("reset overrun", {31'd0, overrun}, 32'd0);
        rst_n = 1'b1;
        step();

        // Directed frame, sink always ready; inputs scrambled after capture.
        set_snap(16'hFFF8, 16'h0004, 16'h1234);
        chk("pre-tick m_tvalid", {31'd0, m_tvalid}, 32'd0);
        tick();
        chk("latency m_tvalid", {31'd0, m_tvalid}, 32'd1);
        chk("first byte header", {24'd0, m_tdata}, 32'hA5);
        chk("seq_num after start", {24'd0, seq_num}, 32'd1);
        set_snap(16'($urandom), 16'($urandom), 16'($urandom));
        wait_idle("t1", 50);
        check_frame("t1", 8'd1, 16'hFFF8, 16'h0004, 16'h1234);

        // Same frame with ready toggling every cycle.
        ready_mode = 1;
        set_snap(16'hFFF8, 16'h0004, 16'h1234);
        tick();
        wait_idle("t2", 100);
        check_frame("t2", 8'd2, 16'hFFF8, 16'h0004, 16'h1234);
        chk("t2 handshake count", wr_ptr - rd_ptr, 32'd0);
        chk("t2 stall stability", stab_err, 32'd0);
        ready_mode = 0;
        step();

        // Second tick three cycles into a frame is dropped.
        ea = 16'($urandom); ma = 16'($urandom); sa = 16'($urandom);
        set_snap(ea, ma, sa);
        tick();
        step();
        step();
        tick();
        wait_idle("t3", 50);
        check_frame("t3", 8'd3, ea, ma, sa);
        chk("t3 single frame", wr_ptr - rd_ptr, 32'd0);
        chk("t3 drop_count", {16'd0, drop_count}, 32'd1);
        chk("t3 overrun", {31'd0, overrun}, 32'd1);
        clear_overrun = 1'b1;
        step();
        clear_overrun = 1'b0;
        chk("t3 cleared drop_count", {16'd0, drop_count}, 32'd0);
        chk("t3 cleared overrun", {31'd0, overrun}, 32'd0);

        // Tick coincident with the final handshake starts a back-to-back frame.
        ea = 16'($urandom); ma = 16'($urandom); sa = 16'($urandom);
        set_snap(ea, ma, sa);
        tick();
        guard = 0;
        while (!(m_tvalid && m_tlast) && guard < 50) begin
            step();
            guard++;
        end
        chk("t4 reached last byte", {31'd0, m_tlast}, 32'd1);
        eb = 16'($urandom); mb = 16'($urandom); sb = 16'($urandom);
        set_snap(eb, mb, sb);
        tick();
        chk("t4 b2b m_tvalid", {31'd0, m_tvalid}, 32'd1);
        chk("t4 b2b header", {24'd0, m_tdata}, 32'hA5);
        chk("t4 b2b seq_num", {24'd0, seq_num}, 32'd5);
        wait_idle("t4", 50);
        check_frame("t4a", 8'd4, ea, ma, sa);
        check_frame("t4b", 8'd5, eb, mb, sb);
        chk("t4 no drop", {16'd0, drop_count}, 32'd0);

        // Tick held high for 20 cycles counts once.
        ea = 16'($urandom); ma = 16'($urandom); sa = 16'($urandom);
        set_snap(ea, ma, sa);
        update_tick = 1'b1;
        repeat (20) step();
        update_tick = 1'b0;
        wait_idle("t5", 50);
        check_frame("t5", 8'd6, ea, ma, sa);
        chk("t5 single frame", wr_ptr - rd_ptr, 32'd0);

        // Disabled ticks are ignored and not counted.
        enable = 1'b0;
        tick();
        repeat (5) step();
        chk("t5 disabled busy", {31'd0, busy}, 32'd0);
        chk("t5 disabled no bytes", wr_ptr - rd_ptr, 32'd0);
        chk("t5 disabled drop_count", {16'd0, drop_count}, 32'd0);
        chk("t5 disabled seq_num", {24'd0, seq_num}, 32'd6);
        enable = 1'b1;

        // Random frames with random backpressure; enable drops mid-frame once.
        ready_mode = 2;
        exp_seq = 8'd6;
        for (int i = 0; i < 4; i++) begin
            ea = 16'($urandom); ma = 16'($urandom); sa = 16'($urandom);
            set_snap(ea, ma, sa);
            tick();
            exp_seq = exp_seq + 8'd1;
            if (i == 1) enable = 1'b0;
            set_snap(16'($urandom), 16'($urandom), 16'($urandom));
            wait_idle("rand", 300);
            enable = 1'b1;
            check_frame($sformatf("rand%0d", i), exp_seq, ea, ma, sa);
        end
        chk("rand stall stability", stab_err, 32'd0);
        ready_mode = 0;
        step();

        // Reset at byte index 4 aborts the frame immediately.
        set_snap(16'($urandom), 16'($urandom), 16'($urandom));
        tick();
        repeat (4) step();
        chk("t6 mid-frame m_tvalid", {31'd0, m_tvalid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6 reset m_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("t6 reset busy", {31'd0, busy}, 32'd0);
        chk("t6 reset seq_num", {24'd0, seq_num}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        rd_ptr = wr_ptr;
        ea = 16'($urandom); ma = 16'($urandom); sa = 16'($urandom);
        set_snap(ea, ma, sa);
        tick();
        wait_idle("t6", 50);
        check_frame("t6", 8'd1, ea, ma, sa);
        chk("final stall stability", stab_err, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
